lif_scheduler: RTL and testbench

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_pkg.sv | 16 +
 rtl/lif_update.sv | 37 +++
 rtl/lif_scheduler.sv | 115 +++++++++++
 tb/tb_lif_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and defaults for the time-multiplexed leaky integrate-and-fire scheduler.
package lif_pkg;

  localparam int DATA_W = 8;
  localparam int REFR_W = 4;

  localparam logic [DATA_W-1:0] DEF_THRESHOLD = 8'd200;
  localparam int                DEF_REFRACT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } lif_state_e;

endpackage

// File: rtl/lif_update.sv
// Single-neuron LIF update: refractory hold, leak by halving, saturating integrate, fire.
module lif_update
  import lif_pkg::*;
#(
  parameter logic [DATA_W-1:0] THRESHOLD = DEF_THRESHOLD,
  parameter int                REFRACT   = DEF_REFRACT
) (
  input  logic [DATA_W-1:0] i_current,
  input  logic [DATA_W-1:0] i_state,
  input  logic [REFR_W-1:0] i_refr,
  output logic [DATA_W-1:0] o_state,
  output logic [REFR_W-1:0] o_refr,
  output logic              o_spike
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_sat;

  assign w_sum = {1'b0, i_current} + {2'b0, i_state[DATA_W-1:1]};
  assign w_sat = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    o_state = '0;
    o_refr  = '0;
    o_spike = 1'b0;
    if (i_refr != '0) begin
      o_refr = i_refr - 1'b1;
    end else if (w_sat >= THRESHOLD) begin
      o_spike = 1'b1;
      o_refr  = REFR_W'(REFRACT);
    end else begin
      o_state = w_sat;
    end
  end

endmodule

// File: rtl/lif_scheduler.sv
// Timestep scheduler sweeping N_NEURONS virtual neurons through one lif_update datapath.
// Define LIF_SCHED_AUTORUN_EN to start a new timestep every time the FSM returns to idle.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int                N_NEURONS = 4,
  parameter logic [DATA_W-1:0] THRESHOLD = DEF_THRESHOLD,
  parameter int                REFRACT   = DEF_REFRACT,
  localparam int               AW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cur_wr_en,
  input  logic [AW-1:0]        cur_wr_addr,
  input  logic [DATA_W-1:0]    cur_wr_data,
  input  logic                 run,
  output logic                 busy,
  output logic                 step_done,
  output logic [N_NEURONS-1:0] spike_vec,
  input  logic [AW-1:0]        state_sel,
  output logic [DATA_W-1:0]    state_out
);

  lif_state_e r_fsm, w_fsm_nxt;

  logic [AW-1:0]        r_idx;
  logic [DATA_W-1:0]    r_cur  [N_NEURONS];
  logic [DATA_W-1:0]    r_mem  [N_NEURONS];
  logic [REFR_W-1:0]    r_refr [N_NEURONS];
  logic [N_NEURONS-1:0] r_shadow;
  logic [N_NEURONS-1:0] r_spike_vec;

  logic              w_run_req, w_start, w_last, w_spike;
  logic [DATA_W-1:0] w_mem_nxt;
  logic [REFR_W-1:0] w_refr_nxt;

`ifdef LIF_SCHED_AUTORUN_EN
  assign w_run_req = 1'b1;
`else
  assign w_run_req = run;
`endif

  assign w_last = (r_idx == AW'(N_NEURONS - 1));

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_start   = 1'b0;
    busy      = 1'b0;
    step_done = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (w_run_req) begin
          w_fsm_nxt = ST_UPDATE;
          w_start   = 1'b1;
        end
      end
      ST_UPDATE: begin
        busy = 1'b1;
        if (w_last) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        step_done = 1'b1;
        w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  lif_update #(
    .THRESHOLD (THRESHOLD),
    .REFRACT   (REFRACT)
  ) u_update (
    .i_current (r_cur[r_idx]),
    .i_state   (r_mem[r_idx]),
    .i_refr    (r_refr[r_idx]),
    .o_state   (w_mem_nxt),
    .o_refr    (w_refr_nxt),
    .o_spike   (w_spike)
  );

  // NOTE: the small per-neuron arrays are flops, so reset clears them; a RAM could not be reset this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_shadow    <= '0;
      r_spike_vec <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_cur[i]  <= '0;
        r_mem[i]  <= '0;
        r_refr[i] <= '0;
      end
    end else begin
      if (cur_wr_en && (int'(cur_wr_addr) < N_NEURONS)) r_cur[cur_wr_addr] <= cur_wr_data;
      if (w_start) r_shadow <= '0;
      if (r_fsm == ST_UPDATE) begin
        r_mem[r_idx]    <= w_mem_nxt;
        r_refr[r_idx]   <= w_refr_nxt;
        r_shadow[r_idx] <= w_spike;
        r_idx           <= w_last ? '0 : r_idx + 1'b1;
      end
      if (r_fsm == ST_DONE) r_spike_vec <= r_shadow;
    end
  end

  assign spike_vec = r_spike_vec;
  assign state_out = (int'(state_sel) < N_NEURONS) ? r_mem[state_sel] : '0;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler against a whole-timestep behavioural neuron model.
module tb_lif_scheduler;

  localparam int N   = 4;
  localparam int THR = 200;
  localparam int REF = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         cur_wr_en;
  logic [1:0]   cur_wr_addr;
  logic [7:0]   cur_wr_data;
  logic         run;
  logic         busy;
  logic         step_done;
  logic [N-1:0] spike_vec;
  logic [1:0]   state_sel;
  logic [7:0]   state_out;

  int n_checks = 0;
  int n_errors = 0;

  int           m_cur  [N];
  int           m_mem  [N];
  int           m_refr [N];
  logic [N-1:0] m_spk;
  logic [7:0]   obs    [N];

  lif_scheduler #(.N_NEURONS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .cur_wr_en   (cur_wr_en),
    .cur_wr_addr (cur_wr_addr),
    .cur_wr_data (cur_wr_data),
    .run         (run),
    .busy        (busy),
    .step_done   (step_done),
    .spike_vec   (spike_vec),
    .state_sel   (state_sel),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  // Whole-timestep reference: every neuron updated from the rules in one pass.
  function automatic void model_step();
    int sum;
    m_spk = '0;
    for (int i = 0; i < N; i++) begin
      if (m_refr[i] > 0) begin
        m_mem[i]  = 0;
        m_refr[i] = m_refr[i] - 1;
      end else begin
        sum = m_cur[i] + m_mem[i] / 2;
        if (sum > 255) sum = 255;
        if (sum >= THR) begin
          m_spk[i]  = 1'b1;
          m_mem[i]  = 0;
          m_refr[i] = REF;
        end else begin
          m_mem[i] = sum;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cur[i]  = 0;
      m_mem[i]  = 0;
      m_refr[i] = 0;
    end
    m_spk = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_states();
    for (int i = 0; i < N; i++) begin
      state_sel = 2'(i);
      #1;
      obs[i] = state_out;
    end
  endtask

  task automatic write_cur(input int addr, input int data);
    cur_wr_en   = 1'b1;
    cur_wr_addr = 2'(addr);
    cur_wr_data = 8'(data);
    tick();
    cur_wr_en   = 1'b0;
    m_cur[addr] = data;
  endtask

  // Pulses run, returns cycles until step_done (-1 on timeout), then waits for spike_vec to load.
  task automatic do_step(output int lat);
    lat = -1;
    run = 1'b1;
    for (int c = 1; c <= N + 8; c++) begin
      tick();
      run = 1'b0;
      if (step_done === 1'b1) begin
        lat = c;
        break;
      end
    end
    tick();
    model_step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cur_wr_en = 1'b0; cur_wr_addr = '0; cur_wr_data = '0; run = 1'b0; state_sel = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    tick();
    sample_states();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (obs[i] !== 8'd0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: got %0d expected 0", i, obs[i]);
      end
    end
    n_checks++;
    if (spike_vec !== '0 || busy !== 1'b0 || step_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: spike_vec=%b busy=%b step_done=%b expected 0 0 0", spike_vec, busy, step_done);
    end
  endtask

  task automatic test_integrate();
    int lat;
    write_cur(0, 100);
    for (int s = 1; s <= 2; s++) begin
      do_step(lat);
      n_checks++;
      if (lat !== N + 1) begin
        n_errors++;
        $display("FAIL integ_latency step%0d: got %0d expected %0d", s, lat, N + 1);
      end
      sample_states();
      n_checks++;
      if (obs[0] !== 8'(m_mem[0]) || obs[0] !== ((s == 1) ? 8'd100 : 8'd150)) begin
        n_errors++;
        $display("FAIL integ_state step%0d: got %0d expected %0d", s, obs[0], m_mem[0]);
      end
      n_checks++;
      if (spike_vec !== 4'b0000) begin
        n_errors++;
        $display("FAIL integ_spike step%0d: got %b expected 0000", s, spike_vec);
      end
    end
  endtask

  task automatic test_refractory();
    int lat;
    write_cur(2, 255);
    for (int s = 1; s <= 4; s++) begin
      do_step(lat);
      sample_states();
      n_checks++;
      if (spike_vec[2] !== ((s == 1 || s == 4) ? 1'b1 : 1'b0) || spike_vec !== m_spk) begin
        n_errors++;
        $display("FAIL refr_spike step%0d: got %b expected %b", s, spike_vec, m_spk);
      end
      n_checks++;
      if (obs[2] !== 8'd0 || obs[0] !== 8'(m_mem[0])) begin
        n_errors++;
        $display("FAIL refr_state step%0d: got n2=%0d n0=%0d expected 0 %0d", s, obs[2], obs[0], m_mem[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_busy: got %b expected 1", busy);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int c = 0; c < N + 6; c++) begin
      if (step_done === 1'b1) dones++;
      tick();
    end
    model_step();
    n_checks++;
    if (dones !== 1) begin
      n_errors++;
      $display("FAIL b2b_done_count: got %0d expected 1", dones);
    end
    sample_states();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (obs[i] !== 8'(m_mem[i])) begin
        n_errors++;
        $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, obs[i], m_mem[i]);
      end
    end
  endtask

  task automatic test_mid_write();
    int lat;
    lat = -1;
    run = 1'b1;
    tick();          // neuron 0 in update
    run = 1'b0;
    tick();          // neuron 1 in update
    cur_wr_en = 1'b1; cur_wr_addr = 2'd3; cur_wr_data = 8'd200;
    m_cur[3] = 200;
    for (int c = 3; c <= N + 8; c++) begin
      tick();
      cur_wr_en = 1'b0;
      if (step_done === 1'b1) begin
        lat = c;
        break;
      end
    end
    tick();
    model_step();
    n_checks++;
    if (lat !== N + 1) begin
      n_errors++;
      $display("FAIL midwr_latency: got %0d expected %0d", lat, N + 1);
    end
    n_checks++;
    if (spike_vec[3] !== 1'b1 || spike_vec !== m_spk) begin
      n_errors++;
      $display("FAIL midwr_spike: got %b expected %b", spike_vec, m_spk);
    end
  endtask

  task automatic test_random();
    int lat;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) write_cur(i, int'($urandom_range(0, 255)));
      do_step(lat);
      sample_states();
      n_checks++;
      if (spike_vec !== m_spk || lat !== N + 1) begin
        n_errors++;
        $display("FAIL rand_step%0d: spike_vec=%b lat=%0d expected %b %0d", s, spike_vec, lat, m_spk, N + 1);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (obs[i] !== 8'(m_mem[i])) begin
          n_errors++;
          $display("FAIL rand_state s%0d n%0d: got %0d expected %0d", s, i, obs[i], m_mem[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones, lat;
    for (int i = 0; i < N; i++) write_cur(i, 255);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();          // neuron 2 in update
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (busy !== 1'b0 || step_done !== 1'b0 || spike_vec !== '0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: busy=%b step_done=%b spike_vec=%b expected 0 0 0", busy, step_done, spike_vec);
    end
    sample_states();
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (obs[i] !== 8'd0) begin
        n_errors++;
        $display("FAIL rstmid_state[%0d]: got %0d expected 0", i, obs[i]);
      end
    end
    tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < N + 4; c++) begin
      tick();
      if (step_done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_errors++;
      $display("FAIL rstmid_no_done: got %0d active cycles expected 0", dones);
    end
    do_step(lat);
    sample_states();
    n_checks++;
    if (obs[0] !== 8'd0 || obs[3] !== 8'd0 || spike_vec !== '0) begin
      n_errors++;
      $display("FAIL rstmid_currents: n0=%0d n3=%0d spike_vec=%b expected 0 0 0", obs[0], obs[3], spike_vec);
    end
  endtask

  initial begin
    test_reset();
    test_integrate();
    test_refractory();
    test_back_to_back();
    test_mid_write();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
